// File: rtl/dvfs_pkg.sv
// Shared types and constants for the DVFS governor and its handshake channels.
package dvfs_pkg;

  localparam int OPP_NUM  = 4;
  localparam int OPP_BITS = 2;
  localparam logic [7:0] UTIL_MAX = 8'd100;

  typedef logic [OPP_BITS-1:0] opp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    V_REQ = 3'd1,
    V_REL = 3'd2,
    C_REQ = 3'd3,
    C_REL = 3'd4
  } dvfs_state_e;

  function automatic logic [7:0] clamp_util(input logic [7:0] u);
    if (u > UTIL_MAX) begin
      return UTIL_MAX;
    end else begin
      return u;
    end
  endfunction

endpackage

// File: rtl/dvfs_handshake.sv
// One 4-phase req/ack channel: registered req/level outputs plus a per-phase
// timeout counter. The governor FSM decides phase transitions.
module dvfs_handshake #(
  parameter int LVL_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_nxt,
  input  logic             active,
  input  logic             phase_chg,
  input  logic [LVL_W-1:0] level_nxt,
  output logic             req,
  output logic [LVL_W-1:0] level,
  output logic             timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             req_q, req_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next request, latched level and phase-age counter.
  always_comb begin
    req_d   = req_nxt;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (req_nxt) begin
      level_d = level_nxt;
    end else begin
      level_d = level_q;
    end
    if (!active || phase_chg) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req     = req_q;
  assign level   = level_q;
  assign timeout = active && (cnt_q == TO_LAST);

endmodule

// File: rtl/dvfs_governor.sv
// Closed-loop DVFS governor: votes on utilization samples and sequences the
// voltage and clock channels (voltage first going up, clock first going down).
module dvfs_governor
  import dvfs_pkg::*;
#(
  parameter int NUM_OPP     = OPP_NUM,
  parameter int OPP_W       = OPP_BITS,
  parameter int UP_THRESH   = 80,
  parameter int DOWN_THRESH = 30,
  parameter int UP_CONSEC   = 2,
  parameter int DOWN_CONSEC = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             util_valid,
  input  logic [7:0]       util_percent,
  input  logic             force_en,
  input  logic [OPP_W-1:0] force_opp,
  output logic             vreg_req,
  output logic [OPP_W-1:0] vreg_level,
  input  logic             vreg_ack,
  output logic             clk_req,
  output logic [OPP_W-1:0] clk_level,
  input  logic             clk_ack,
  output logic [OPP_W-1:0] cur_opp,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  localparam int VW = $clog2(((UP_CONSEC > DOWN_CONSEC) ? UP_CONSEC : DOWN_CONSEC) + 1);
  localparam logic [VW-1:0]    UP_N    = VW'(UP_CONSEC);
  localparam logic [VW-1:0]    DN_N    = VW'(DOWN_CONSEC);
  localparam logic [OPP_W-1:0] MAX_OPP = OPP_W'(NUM_OPP - 1);
  localparam logic [7:0]       UP_T    = 8'(UP_THRESH);
  localparam logic [7:0]       DN_T    = 8'(DOWN_THRESH);

  dvfs_state_e      state_q, state_d;
  logic [OPP_W-1:0] cur_q, cur_d, tgt_q, tgt_d, force_tgt;
  logic [VW-1:0]    up_q, up_d, dn_q, dn_d;
  logic             err_q, err_d, busy_q;
  logic [7:0]       util_c;
  logic             v_to, c_to, up_dir;

  // Voting, force override and transition sequencing.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    up_d      = up_q;
    dn_d      = dn_q;
    util_c    = clamp_util(util_percent);
    up_dir    = (tgt_q > cur_q);
    if (force_opp > MAX_OPP) begin
      force_tgt = MAX_OPP;
    end else begin
      force_tgt = force_opp;
    end

    case (state_q)
      IDLE: begin
        if (err_q || force_en) begin
          up_d = '0;
          dn_d = '0;
          if (!err_q && (force_tgt != cur_q)) begin
            tgt_d   = force_tgt;
            state_d = (force_tgt > cur_q) ? V_REQ : C_REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (up_q == UP_N) begin
          up_d = '0;
          dn_d = '0;
          if (cur_q < MAX_OPP) begin
            tgt_d   = cur_q + OPP_W'(1);
            state_d = V_REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (dn_q == DN_N) begin
          up_d = '0;
          dn_d = '0;
          if (cur_q > '0) begin
            tgt_d   = cur_q - OPP_W'(1);
            state_d = C_REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (util_valid) begin
          if (util_c >= UP_T) begin
            up_d = (up_q == UP_N) ? up_q : up_q + VW'(1);
            dn_d = '0;
          end else if (util_c <= DN_T) begin
            dn_d = (dn_q == DN_N) ? dn_q : dn_q + VW'(1);
            up_d = '0;
          end else begin
            up_d = '0;
            dn_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      V_REQ: begin
        if (v_to) begin
          state_d = IDLE;
        end else if (vreg_ack) begin
          state_d = V_REL;
        end else begin
          state_d = V_REQ;
        end
      end
      V_REL: begin
        if (v_to) begin
          state_d = IDLE;
        end else if (!vreg_ack) begin
          if (up_dir) begin
            state_d = C_REQ;
          end else begin
            state_d = IDLE;
            cur_d   = tgt_q;
          end
        end else begin
          state_d = V_REL;
        end
      end
      C_REQ: begin
        if (c_to) begin
          state_d = IDLE;
        end else if (clk_ack) begin
          state_d = C_REL;
        end else begin
          state_d = C_REQ;
        end
      end
      C_REL: begin
        if (c_to) begin
          state_d = IDLE;
        end else if (!clk_ack) begin
          if (up_dir) begin
            state_d = IDLE;
            cur_d   = tgt_q;
          end else begin
            state_d = V_REQ;
          end
        end else begin
          state_d = C_REL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A timeout wins over a same-cycle clear so the fault is never lost.
    if (v_to || c_to) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Governor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  dvfs_handshake #(.LVL_W(OPP_W), .TIMEOUT(TIMEOUT)) u_vreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_nxt   (state_d == V_REQ),
    .active    ((state_q == V_REQ) || (state_q == V_REL)),
    .phase_chg (state_d != state_q),
    .level_nxt (tgt_d),
    .req       (vreg_req),
    .level     (vreg_level),
    .timeout   (v_to)
  );

  dvfs_handshake #(.LVL_W(OPP_W), .TIMEOUT(TIMEOUT)) u_clk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_nxt   (state_d == C_REQ),
    .active    ((state_q == C_REQ) || (state_q == C_REL)),
    .phase_chg (state_d != state_q),
    .level_nxt (tgt_d),
    .req       (clk_req),
    .level     (clk_level),
    .timeout   (c_to)
  );

  assign cur_opp = cur_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
